// File: rtl/mc_sequencer_if.sv
// Memory handshake bundle between the instruction sequencer and the
// instruction/data memory ports.
interface mc_sequencer_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ack,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ack,
        output dmem_ack
    );
endinterface

// File: rtl/mc_sequencer.sv
// Multi-cycle RV64 instruction sequencer: steps the shared datapath through
// FETCH/DECODE/EXEC/MEM/WB one instruction at a time, drives the memory
// handshakes, keeps instret/cycle counters and traps on memory timeout.
module mc_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_en,
    mc_sequencer_if.master   mem,
    input  logic             Memread,
    input  logic             Memwrite,
    input  logic             Regwrite,
    input  logic             jal,
    input  logic             jalr,
    input  logic             br_taken,
    output logic             ir_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] instret,
    output logic [CNT_W-1:0] cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_ERR
    } state_t;

    // The wait counter only has to reach TIMEOUT-1: the trap fires on the
    // cycle that would have taken it to TIMEOUT.
    localparam int                WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] LIMIT  = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

    state_t            state_q;
    logic [WAIT_W-1:0] wait_q;
    logic              imem_req_q;
    logic              dmem_req_q;
    logic              dmem_we_q;
    logic              rf_we_q;
    logic              pc_we_q;
    logic [1:0]        pc_sel_q;
    logic              busy_q;
    logic              err_q;
    logic [CNT_W-1:0]  instret_q;
    logic [CNT_W-1:0]  cycles_q;
    logic              memread_q;
    logic              memwrite_q;
    logic              regwrite_q;
    logic              jal_q;
    logic              jalr_q;
    logic              br_q;
    logic              limit_hit;

    // jalr target wins over jal/branch, which win over sequential pc+4.
    function automatic logic [1:0] pc_target(input logic jr, input logic j, input logic br);
        if (jr) begin
            return 2'd2;
        end else if (j || br) begin
            return 2'd1;
        end
        return 2'd0;
    endfunction

    // Wait limit reached this cycle; an ack in the same cycle takes priority.
    assign limit_hit = (TIMEOUT > 0) && (wait_q == LIMIT);

    // Sequencer FSM with registered enables, handshakes and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wait_q     <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            pc_we_q    <= 1'b0;
            pc_sel_q   <= 2'd0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            instret_q  <= '0;
            cycles_q   <= '0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            regwrite_q <= 1'b0;
            jal_q      <= 1'b0;
            jalr_q     <= 1'b0;
            br_q       <= 1'b0;
        end else begin
            cycles_q <= cycles_q + 1'b1;
            rf_we_q  <= 1'b0;
            pc_we_q  <= 1'b0;
            pc_sel_q <= 2'd0;
            case (state_q)
                S_IDLE: begin
                    if (run_en) begin
                        state_q    <= S_FETCH;
                        imem_req_q <= 1'b1;
                        busy_q     <= 1'b1;
                        wait_q     <= '0;
                    end
                end
                S_FETCH: begin
                    if (mem.imem_ack) begin
                        state_q    <= S_DECODE;
                        imem_req_q <= 1'b0;
                    end else if (limit_hit) begin
                        state_q    <= S_ERR;
                        imem_req_q <= 1'b0;
                        busy_q     <= 1'b0;
                        err_q      <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_DECODE: begin
                    memread_q  <= Memread;
                    memwrite_q <= Memwrite;
                    regwrite_q <= Regwrite;
                    jal_q      <= jal;
                    jalr_q     <= jalr;
                    state_q    <= S_EXEC;
                end
                S_EXEC: begin
                    br_q <= br_taken;
                    if (memread_q || memwrite_q) begin
                        state_q    <= S_MEM;
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= memwrite_q;
                        wait_q     <= '0;
                    end else begin
                        state_q  <= S_WB;
                        rf_we_q  <= regwrite_q;
                        pc_we_q  <= 1'b1;
                        pc_sel_q <= pc_target(jalr_q, jal_q, br_taken);
                    end
                end
                S_MEM: begin
                    if (mem.dmem_ack) begin
                        state_q    <= S_WB;
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        rf_we_q    <= regwrite_q;
                        pc_we_q    <= 1'b1;
                        pc_sel_q   <= pc_target(jalr_q, jal_q, br_q);
                    end else if (limit_hit) begin
                        state_q    <= S_ERR;
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        busy_q     <= 1'b0;
                        err_q      <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_WB: begin
                    instret_q <= instret_q + 1'b1;
                    if (run_en) begin
                        state_q    <= S_FETCH;
                        imem_req_q <= 1'b1;
                        wait_q     <= '0;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_ERR: begin
                    state_q <= S_ERR;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem.imem_req = imem_req_q;
    assign mem.dmem_req = dmem_req_q;
    assign mem.dmem_we  = dmem_we_q;
    assign ir_we        = imem_req_q & mem.imem_ack;
    assign rf_we        = rf_we_q;
    assign pc_we        = pc_we_q;
    assign pc_sel       = pc_sel_q;
    assign busy         = busy_q;
    assign err          = err_q;
    assign instret      = instret_q;
    assign cycles       = cycles_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Scoreboard bench for mc_sequencer: a driver issues instructions with random
// decode strobes and memory wait states and queues the expected write-back
// and data-access results; a monitor pops and compares as the DUT presents them.
module tb_mc_sequencer;

    localparam int TO = 4;
    localparam int CW = 64;

    typedef struct {
        logic            rf;
        logic [1:0]      sel;
        longint unsigned cyc;
        longint unsigned idx;
    } wb_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run_en = 1'b0;
    logic          Memread = 1'b0;
    logic          Memwrite = 1'b0;
    logic          Regwrite = 1'b0;
    logic          jal = 1'b0;
    logic          jalr = 1'b0;
    logic          br_taken = 1'b0;
    logic          ir_we;
    logic          rf_we;
    logic          pc_we;
    logic [1:0]    pc_sel;
    logic          busy;
    logic          err;
    logic [CW-1:0] instret;
    logic [CW-1:0] cycles;

    mc_sequencer_if mem_if();

    mc_sequencer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run_en   (run_en),
        .mem      (mem_if),
        .Memread  (Memread),
        .Memwrite (Memwrite),
        .Regwrite (Regwrite),
        .jal      (jal),
        .jalr     (jalr),
        .br_taken (br_taken),
        .ir_we    (ir_we),
        .rf_we    (rf_we),
        .pc_we    (pc_we),
        .pc_sel   (pc_sel),
        .busy     (busy),
        .err      (err),
        .instret  (instret),
        .cycles   (cycles)
    );

    always #5 clk = ~clk;

    int              errors = 0;
    int              checks = 0;
    longint unsigned tbcyc = 0;
    longint unsigned model_ret = 0;
    wb_t             wb_q[$];
    logic            mem_q[$];
    wb_t             mon_w;
    logic            mon_we;

    // Reference cycle count: one per rising edge since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tbcyc = 0;
        else        tbcyc = tbcyc + 1;
    end

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic sig(input int s);
        case (s)
            0:       return mem_if.imem_req;
            1:       return mem_if.dmem_req;
            default: return pc_we;
        endcase
    endfunction

    task automatic wait_for(input int s, input string nm);
        int n = 0;
        while (!sig(s) && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk(nm, sig(s), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run_en = 1'b0;
        mem_if.imem_ack = 1'b0;
        mem_if.dmem_ack = 1'b0;
        model_ret = 0;
        wb_q.delete();
        mem_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issue one instruction; returns at the negedge of its write-back cycle.
    task automatic run_instr(input bit mr, input bit mw, input bit rw, input bit j,
                             input bit jr, input bit br, input int iw, input int dw,
                             input bit stop);
        wb_t             w;
        longint unsigned c0;
        Memread = mr; Memwrite = mw; Regwrite = rw;
        jal = j; jalr = jr; br_taken = br;
        mem_if.imem_ack = 1'b0;
        wait_for(0, "fetch_req");
        c0 = tbcyc;
        w.rf  = rw;
        w.sel = jr ? 2'd2 : ((j || br) ? 2'd1 : 2'd0);
        w.cyc = c0 + longint'(iw) + 3 + ((mr || mw) ? longint'(dw) + 1 : 0);
        w.idx = model_ret;
        model_ret++;
        wb_q.push_back(w);
        if (mr || mw) mem_q.push_back(mw);
        repeat (iw) begin
            mem_if.dmem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        mem_if.dmem_ack = 1'b0;
        mem_if.imem_ack = 1'b1;
        #1 chk("ir_we", ir_we, 1);
        @(negedge clk);
        mem_if.imem_ack = 1'b0;
        if (stop) run_en = 1'b0;
        if (mr || mw) begin
            wait_for(1, "dmem_req");
            repeat (dw) begin
                mem_if.imem_ack = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            mem_if.imem_ack = 1'b0;
            mem_if.dmem_ack = 1'b1;
            @(negedge clk);
            mem_if.dmem_ack = 1'b0;
        end
        wait_for(2, "wb_reached");
    endtask

    // Monitor: pops expectations whenever the DUT retires or completes a data access.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                chk("cycles", cycles, tbcyc);
                if (mem_if.dmem_req && mem_if.dmem_ack) begin
                    if (mem_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL dmem_access: got unexpected access expected none");
                    end else begin
                        mon_we = mem_q.pop_front();
                        chk("dmem_we", mem_if.dmem_we, mon_we);
                    end
                end
                if (pc_we) begin
                    if (wb_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL wb: got unexpected write-back expected none");
                    end else begin
                        mon_w = wb_q.pop_front();
                        chk("rf_we", rf_we, mon_w.rf);
                        chk("pc_sel", pc_sel, mon_w.sel);
                        chk("instret", instret, mon_w.idx);
                        chk("wb_cycle", tbcyc, mon_w.cyc);
                        chk("busy_wb", busy, 1);
                    end
                end
            end
        end
    end

    initial begin
        int cnt;
        mem_if.imem_ack = 1'b0;
        mem_if.dmem_ack = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_imem_req", mem_if.imem_req, 0);
        chk("rst_dmem_req", mem_if.dmem_req, 0);
        chk("rst_dmem_we", mem_if.dmem_we, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_pc_we", pc_we, 0);
        chk("rst_pc_sel", pc_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_instret", instret, 0);
        chk("rst_cycles", cycles, 0);
        do_reset();

        // Idle holds without run_en
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_req", mem_if.imem_req, 0);

        // Directed: three zero-wait ALU ops, load, store, load+store, jal/jalr, branch
        run_en = 1'b1;
        repeat (3) run_instr(0, 0, 1, 0, 0, 0, 0, 0, 0);
        run_instr(1, 0, 1, 0, 0, 0, 0, 3, 0);
        run_instr(0, 1, 0, 0, 0, 0, 0, 0, 0);
        run_instr(1, 1, 1, 0, 0, 0, 1, 2, 0);
        run_instr(0, 0, 1, 1, 1, 0, 0, 0, 0);
        run_instr(0, 0, 0, 0, 0, 1, 0, 0, 0);
        run_instr(0, 0, 1, 1, 0, 0, TO - 1, 0, 0);
        run_instr(1, 0, 1, 0, 1, 1, 0, TO - 1, 0);

        // Random stream; the last one drops run_en so WB returns to IDLE
        for (int i = 0; i < 60; i++) begin
            run_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, TO - 1)), int'($urandom_range(0, TO - 1)),
                      i == 59);
        end
        @(negedge clk);
        chk("stop_busy", busy, 0);
        chk("stop_req", mem_if.imem_req, 0);
        @(negedge clk);
        chk("stop_idle_req", mem_if.imem_req, 0);

        // Reset in the middle of a data access
        do_reset();
        run_en = 1'b1;
        Memread = 1'b1; Memwrite = 1'b0; Regwrite = 1'b1;
        jal = 1'b0; jalr = 1'b0; br_taken = 1'b0;
        wait_for(0, "mr_fetch_req");
        mem_if.imem_ack = 1'b1;
        @(negedge clk);
        mem_if.imem_ack = 1'b0;
        wait_for(1, "mr_dmem_req");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_dmem_req", mem_if.dmem_req, 0);
        chk("mr_pc_we", pc_we, 0);
        chk("mr_rf_we", rf_we, 0);
        chk("mr_busy", busy, 0);
        chk("mr_instret", instret, 0);
        do_reset();

        // Fetch timeout: no imem ack at all
        run_en = 1'b1;
        wait_for(0, "to_fetch_req");
        cnt = 0;
        while (mem_if.imem_req && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chk("to_fetch_len", cnt, TO);
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        chk("to_req_drop", mem_if.imem_req, 0);
        repeat (3) @(negedge clk);
        chk("to_err_sticky", err, 1);
        chk("to_no_restart", mem_if.imem_req, 0);

        // Ack on the last allowed wait cycle wins over the timeout
        do_reset();
        run_en = 1'b1;
        run_instr(0, 0, 1, 0, 0, 0, TO - 1, 0, 1);
        chk("edge_no_err", err, 0);

        // Data timeout on a store
        do_reset();
        run_en = 1'b1;
        Memread = 1'b0; Memwrite = 1'b1; Regwrite = 1'b0;
        wait_for(0, "dto_fetch_req");
        mem_if.imem_ack = 1'b1;
        @(negedge clk);
        mem_if.imem_ack = 1'b0;
        wait_for(1, "dto_dmem_req");
        chk("dto_we", mem_if.dmem_we, 1);
        cnt = 0;
        while (mem_if.dmem_req && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chk("dto_len", cnt, TO);
        chk("dto_err", err, 1);
        chk("dto_busy", busy, 0);
        chk("dto_we_drop", mem_if.dmem_we, 0);
        chk("dto_instret", instret, 0);
        @(negedge clk);

        chk("wb_q_left", wb_q.size(), 0);
        chk("mem_q_left", mem_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Multi-cycle instruction sequencer for the RV64 core.
- Drives the shared datapath (PC, IR, regfile, ALU, memory port) through FETCH/DECODE/EXEC/MEM/WB, one instruction at a time.
- Takes decoded strobes from the combinational control decoder and the branch-compare result, and produces per-cycle datapath enables and memory handshakes.
- Also maintains the retired-instruction and cycle counters, and traps on memory timeout.

Parameters:
- TIMEOUT, 16, max cycles a memory request may wait for ack; 0 disables the timeout.
- CNT_W, 64, width of the instret and cycle counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run_en  input  1  permits starting a new fetch.
- imem_req  output  1  instruction fetch request.
- imem_ack  input  1  fetch data valid this cycle.
- dmem_req  output  1  data memory request.
- dmem_we  output  1  data request is a store.
- dmem_ack  input  1  data access complete this cycle.
- Memread  input  1  decoded load.
- Memwrite  input  1  decoded store.
- Regwrite  input  1  decoded register write.
- jal  input  1  decoded jal.
- jalr  input  1  decoded jalr.
- br_taken  input  1  branch condition true (already qualified by beq..bgeu).
- ir_we  output  1  load IR.
- rf_we  output  1  regfile write enable.
- pc_we  output  1  PC update enable.
- pc_sel  output  2  0=pc+4, 1=pc+imm (taken branch/jal), 2=jalr target.
- busy  output  1  high in any state except IDLE and ERR.
- err  output  1  sticky memory-timeout trap.
- instret  output  CNT_W  retired instruction count.
- cycles  output  CNT_W  cycles since reset.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0; counters 0; latched decode regs 0.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, ERR.
- IDLE:
  - If run_en=1, go to FETCH next cycle; else stay.
- FETCH:
  - imem_req=1 every cycle in this state.
  - On imem_ack=1: ir_we=1 that same cycle, go to DECODE.
  - Ack in the first FETCH cycle is legal (zero wait).
- DECODE (1 cycle):
  - At the end of the cycle, latch Memread, Memwrite, Regwrite, jal, jalr into internal regs.
  - Go to EXEC.
- EXEC (1 cycle):
  - Latch br_taken at the end of the cycle.
  - If latched Memread|Memwrite, go to MEM; else go to WB.
- MEM:
  - dmem_req=1 and dmem_we=latched Memwrite, held until dmem_ack.
  - On dmem_ack, go to WB.
  - If Memread and Memwrite are both latched, the access is a store.
- WB (1 cycle):
  - rf_we=latched Regwrite; pc_we=1.
  - pc_sel = 2 if jalr; else 1 if jal or br_taken; else 0. jalr has priority over jal.
  - instret increments.
  - Next state is FETCH if run_en=1, else IDLE.
- Only FETCH, MEM and WB assert outputs. Outputs are registered-state decodes, with no combinational path from inputs except:
  - ir_we follows imem_ack.
  - Handshake transitions depend on imem_ack and dmem_ack.
- Timeout:
  - A wait counter clears on entry to FETCH and on entry to MEM, and increments each cycle the req is high without ack.
  - If TIMEOUT>0 and the count reaches TIMEOUT with no ack that cycle, go to ERR; the request drops next cycle.
  - Ack in the same cycle the limit is reached wins: normal transition, no error.
- ERR:
  - err=1, busy=0, all enables and requests 0.
  - Leaves only via reset.
- Acks arriving while the corresponding req=0 are ignored.
- Counters:
  - cycles increments every cycle after reset, including in ERR; wraps modulo 2^CNT_W.
  - instret wraps modulo 2^CNT_W.
- run_en dropping mid-instruction does not abort it; it is sampled only in IDLE and WB.
- Reset mid-operation: immediate return to IDLE, requests deassert asynchronously, no partial rf_we or pc_we.
- Minimum latencies:
  - ALU instruction: 4 cycles (FETCH, DECODE, EXEC, WB) with zero-wait imem.
  - Load/store: 5 cycles with zero-wait memories.

Test Plan:
- Reset, then run_en=1, imem_ack=1 every cycle, Regwrite=1 (ALU op) -> state sequence FETCH, DECODE, EXEC, WB repeating every 4 cycles; rf_we=1, pc_sel=0 in WB; instret=3 after 12 cycles.
- Load with Memread=1, Regwrite=1, dmem_ack delayed 3 cycles -> dmem_req high for 4 cycles with dmem_we=0, then WB with rf_we=1; total 8 cycles.
- Store Memwrite=1, Regwrite=0 -> dmem_we=1 during MEM; rf_we=0 in WB; then: jal=1,jalr=1 -> pc_sel=2; br_taken=1 only -> pc_sel=1.
- TIMEOUT=4, imem_ack held 0 -> imem_req high 4 cycles, then ERR with err=1 and busy=0; repeat with ack on the 4th wait cycle -> no error, enters DECODE.
- rst_n pulsed low during MEM with dmem_req=1 -> dmem_req=0 immediately, instret unchanged at 0, state IDLE; run_en=0 at WB -> returns to IDLE, busy=0.
